// File: rtl/seg7_pkg.sv
// Shared constants, scan FSM states and BCD-to-segment decode for the
// multiplexed 7-segment display driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic {S_DEAD, S_ON} scan_state_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg7_decode = SEG_0;
      4'd1:    seg7_decode = SEG_1;
      4'd2:    seg7_decode = SEG_2;
      4'd3:    seg7_decode = SEG_3;
      4'd4:    seg7_decode = SEG_4;
      4'd5:    seg7_decode = SEG_5;
      4'd6:    seg7_decode = SEG_6;
      4'd7:    seg7_decode = SEG_7;
      4'd8:    seg7_decode = SEG_8;
      4'd9:    seg7_decode = SEG_9;
      default: seg7_decode = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one BCD digit to active-low segments; a blank
// request overrides the digit value and darkens every segment.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] segment
);

  always_comb begin
    segment = seg7_decode(bcd);
    if (blank) segment = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadowed input,
// dead-time blanking between digits and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 4,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    scan_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LAST = DIV_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] bcd_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;
  logic [NUM_DIGITS-1:0]   lz_mask;

  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             wrap;
  scan_state_t      state;
  scan_state_t      state_nxt;

  logic [3:0] cur_bcd;
  logic       cur_dp;
  logic       cur_blank;
  logic [6:0] dec_seg;

  logic [NUM_DIGITS-1:0] den_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  assign wrap     = en && (div == DIV_LAST);
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // A digit position is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (bcd_sh[4*k +: 4] == 4'd0);
      if (k != 0) lz_mask[k] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_sh   <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
    end else if (load) begin
      bcd_sh   <= bcd_in;
      dp_sh    <= dp_in;
      blank_sh <= blank_in;
    end
  end

  // The digit about to be lit is sampled from the shadow only at the index
  // change, so a load never alters a digit part-way through its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      idx       <= '0;
      cur_bcd   <= '0;
      cur_dp    <= 1'b0;
      cur_blank <= 1'b0;
    end else if (wrap) begin
      div       <= '0;
      idx       <= idx_next;
      cur_bcd   <= bcd_sh[4*idx_next +: 4];
      cur_dp    <= dp_sh[idx_next];
      cur_blank <= blank_sh[idx_next] | ((LZ_SUPPRESS != 0) && lz_mask[idx_next]);
    end else if (en) begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_DEAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      if (div == DIV_LAST)
        state_nxt = (DEAD_CYCLES > 0) ? S_DEAD : S_ON;
      else if ((state == S_DEAD) && ((DEAD_CYCLES == 0) || (div == DEAD_LAST)))
        state_nxt = S_ON;
    end
  end

  seg7_digit_decode u_decode (
    .bcd     (cur_bcd),
    .blank   (cur_blank),
    .segment (dec_seg)
  );

  always_comb begin
    den_nxt = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (en && (state == S_ON)) begin
      den_nxt[idx] = 1'b0;
      seg_nxt      = dec_seg;
      dp_nxt       = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment   <= SEG_BLANK;
      dp        <= 1'b1;
      digit_en  <= '1;
      scan_tick <= 1'b0;
    end else begin
      segment   <= seg_nxt;
      dp        <= dp_nxt;
      digit_en  <= den_nxt;
      scan_tick <= wrap;
    end
  end

endmodule
